// File: rtl/decode_stage.sv
// ----------------------------------------------------------------------------
// decode_stage
//   Registered RV32I decode stage between fetch and execute. Each accepted
//   instruction is split into register fields, given a sign-extended
//   immediate, classified into a one-hot type and mapped to an ALU op code
//   plus control flags. A small skid FIFO holds instructions accepted while
//   execute stalls, so in_ready is a pure register and fetch never sees a
//   combinational path from out_ready.
//
//   Build option: define DECODE_STAGE_ILLEGAL_CHECK_EN to enable illegal
//   encoding detection; otherwise out_illegal is tied to 0.
//
// Ports
//   clk, rst_n        clock, asynchronous active-low reset
//   flush             synchronous kill of everything held or arriving
//   in_valid/ready    fetch handshake (in_ready registered, = !skid_full)
//   in_instr, in_pc   raw instruction and its PC
//   out_valid/ready   execute handshake
//   out_pc            PC of the decoded bundle
//   out_rd/rs1/rs2    register indices, 0 when unused by the type
//   out_funct3        funct3 field
//   out_imm           sign-extended immediate (0 for R-type)
//   out_type          one-hot {J,B,R,S,I,U}, 0 when unrecognised
//   out_alu_op        ADD0 SUB1 SLL2 SLT3 SLTU4 XOR5 SRL6 SRA7 OR8 AND9 PASSB10
//   out_wr_en         rd written and rd != 0
//   out_is_*          load/store/branch/jump class flags
//   out_illegal       illegal encoding flag
// ----------------------------------------------------------------------------
module decode_stage #(
    parameter int XLEN       = 32,
    parameter int PC_W       = 32,
    parameter int SKID_DEPTH = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_instr,
    input  logic [PC_W-1:0] in_pc,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [PC_W-1:0] out_pc,
    output logic [4:0]      out_rd,
    output logic [4:0]      out_rs1,
    output logic [4:0]      out_rs2,
    output logic [2:0]      out_funct3,
    output logic [XLEN-1:0] out_imm,
    output logic [5:0]      out_type,
    output logic [3:0]      out_alu_op,
    output logic            out_wr_en,
    output logic            out_is_load,
    output logic            out_is_store,
    output logic            out_is_branch,
    output logic            out_is_jump,
    output logic            out_illegal
);

    localparam int PTR_W = (SKID_DEPTH > 1) ? $clog2(SKID_DEPTH) : 1;
    localparam int CNT_W = $clog2(SKID_DEPTH + 1);

    localparam logic [5:0] TYPE_U = 6'b000001;
    localparam logic [5:0] TYPE_I = 6'b000010;
    localparam logic [5:0] TYPE_S = 6'b000100;
    localparam logic [5:0] TYPE_R = 6'b001000;
    localparam logic [5:0] TYPE_B = 6'b010000;
    localparam logic [5:0] TYPE_J = 6'b100000;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,  ALU_SUB  = 4'd1,  ALU_SLL = 4'd2, ALU_SLT = 4'd3,
        ALU_SLTU = 4'd4,  ALU_XOR  = 4'd5,  ALU_SRL = 4'd6, ALU_SRA = 4'd7,
        ALU_OR   = 4'd8,  ALU_AND  = 4'd9,  ALU_PASSB = 4'd10
    } alu_op_e;

    typedef struct packed {
        logic [PC_W-1:0] pc;
        logic [4:0]      rd;
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        logic [2:0]      funct3;
        logic [XLEN-1:0] imm;
        logic [5:0]      itype;
        alu_op_e         alu_op;
        logic            wr_en;
        logic            is_load;
        logic            is_store;
        logic            is_branch;
        logic            is_jump;
        logic            illegal;
    } bundle_t;

    function automatic bundle_t decode_instr(input logic [31:0] instr,
                                             input logic [PC_W-1:0] pc);
        bundle_t         b;
        logic [4:0]      op5;
        logic [2:0]      f3;
        logic [31:0]     imm32;
        logic [XLEN-1:0] imm_ext;
        logic            use_rd, use_rs1, use_rs2;
        b     = '0;
        op5   = instr[6:2];
        f3    = instr[14:12];
        imm32 = '0;

        casez (op5)
            5'b0?101:                     b.itype = TYPE_U;
            5'b0000?, 5'b001?0, 5'b11001: b.itype = TYPE_I;
            5'b0100?:                     b.itype = TYPE_S;
            5'b01011, 5'b011?0, 5'b10100: b.itype = TYPE_R;
            5'b11000:                     b.itype = TYPE_B;
            5'b11011:                     b.itype = TYPE_J;
            default:                      b.itype = '0;
        endcase

        if (b.itype == TYPE_I)
            imm32 = {{20{instr[31]}}, instr[31:20]};
        else if (b.itype == TYPE_S)
            imm32 = {{20{instr[31]}}, instr[31:25], instr[11:7]};
        else if (b.itype == TYPE_B)
            imm32 = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
        else if (b.itype == TYPE_U)
            imm32 = {instr[31:12], 12'b0};
        else if (b.itype == TYPE_J)
            imm32 = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};

        // Widen to XLEN by replicating the 32-bit sign bit.
        imm_ext        = {XLEN{imm32[31]}};
        imm_ext[31:0]  = imm32;

        use_rd  = |(b.itype & (TYPE_R | TYPE_I | TYPE_U | TYPE_J));
        use_rs1 = |(b.itype & (TYPE_R | TYPE_I | TYPE_S | TYPE_B));
        use_rs2 = |(b.itype & (TYPE_R | TYPE_S | TYPE_B));

        b.pc     = pc;
        b.funct3 = f3;
        b.imm    = imm_ext;
        b.rd     = use_rd  ? instr[11:7]  : 5'd0;
        b.rs1    = use_rs1 ? instr[19:15] : 5'd0;
        b.rs2    = use_rs2 ? instr[24:20] : 5'd0;

        // instr[30] picks SUB only for register OP; SRA for both OP and OP-IMM.
        case (op5)
            5'b01100, 5'b00100: begin
                case (f3)
                    3'b000:  b.alu_op = (op5 == 5'b01100 && instr[30]) ? ALU_SUB : ALU_ADD;
                    3'b001:  b.alu_op = ALU_SLL;
                    3'b010:  b.alu_op = ALU_SLT;
                    3'b011:  b.alu_op = ALU_SLTU;
                    3'b100:  b.alu_op = ALU_XOR;
                    3'b101:  b.alu_op = instr[30] ? ALU_SRA : ALU_SRL;
                    3'b110:  b.alu_op = ALU_OR;
                    default: b.alu_op = ALU_AND;
                endcase
            end
            5'b01101: b.alu_op = ALU_PASSB;
            5'b11000: b.alu_op = f3[2] ? (f3[1] ? ALU_SLTU : ALU_SLT) : ALU_XOR;
            default:  b.alu_op = ALU_ADD;
        endcase

        b.wr_en     = (b.rd != 5'd0);
        b.is_load   = (op5[4:1] == 4'b0000);
        b.is_store  = (op5[4:1] == 4'b0100);
        b.is_branch = (b.itype == TYPE_B);
        b.is_jump   = (b.itype == TYPE_J) || (op5 == 5'b11001);

`ifdef DECODE_STAGE_ILLEGAL_CHECK_EN
        b.illegal = (instr[1:0] != 2'b11)
                 || (b.itype == 6'b0)
                 || (b.is_branch && f3[2:1] == 2'b01)
                 || (b.is_load && (f3 == 3'b011 || f3[2:1] == 2'b11))
                 || (b.is_store && f3 >= 3'b011)
                 || (b.itype == TYPE_R && instr[31:25] != 7'b0000000
                                       && instr[31:25] != 7'b0100000);
        if (b.illegal) begin
            b.wr_en  = 1'b0;
            b.alu_op = ALU_ADD;
        end
`else
        b.illegal = 1'b0;
`endif
        return b;
    endfunction

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(SKID_DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    bundle_t          out_q, out_d;
    logic             out_valid_q, out_valid_d;
    logic             in_ready_q, in_ready_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [31:0]      skid_instr_q [SKID_DEPTH];
    logic [PC_W-1:0]  skid_pc_q    [SKID_DEPTH];

    logic             in_fire, out_fire, out_load, skid_empty, push, pop;
    logic [31:0]      src_instr;
    logic [PC_W-1:0]  src_pc;
    bundle_t          dec;

    always_comb begin
        // NOTE: every variable gets a default before any branch so no latch is inferred.
        in_fire    = in_valid && in_ready_q;
        out_fire   = out_valid_q && out_ready;
        out_load   = !out_valid_q || out_fire;
        skid_empty = (count_q == '0);
        // Once anything waits in the skid, new input must queue behind it.
        pop        = out_load && !skid_empty;
        push       = in_fire && (!out_load || !skid_empty);
        src_instr  = pop ? skid_instr_q[rd_ptr_q] : in_instr;
        src_pc     = pop ? skid_pc_q[rd_ptr_q]    : in_pc;
        dec        = decode_instr(src_instr, src_pc);

        out_d       = out_q;
        out_valid_d = out_valid_q;
        count_d     = count_q;
        rd_ptr_d    = rd_ptr_q;
        wr_ptr_d    = wr_ptr_q;

        if (flush) begin
            out_valid_d = 1'b0;
            count_d     = '0;
            rd_ptr_d    = '0;
            wr_ptr_d    = '0;
        end else begin
            if (out_load) begin
                out_valid_d = pop || in_fire;
                if (pop || in_fire) out_d = dec;
            end
            if (pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
            if (push) wr_ptr_d = ptr_inc(wr_ptr_q);
            count_d = count_q + CNT_W'(push) - CNT_W'(pop);
        end
        in_ready_d = (count_d != CNT_W'(SKID_DEPTH));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: state registers use non-blocking assignment so all update together at the edge.
        if (!rst_n) begin
            out_q       <= '0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            count_q     <= '0;
            rd_ptr_q    <= '0;
            wr_ptr_q    <= '0;
        end else begin
            out_q       <= out_d;
            out_valid_q <= out_valid_d;
            in_ready_q  <= in_ready_d;
            count_q     <= count_d;
            rd_ptr_q    <= rd_ptr_d;
            wr_ptr_q    <= wr_ptr_d;
        end
    end

    // NOTE: skid storage is not reset; count_q alone decides which entries are live.
    always_ff @(posedge clk) begin
        if (push && !flush) begin
            skid_instr_q[wr_ptr_q] <= in_instr;
            skid_pc_q[wr_ptr_q]    <= in_pc;
        end
    end

    assign in_ready      = in_ready_q;
    assign out_valid     = out_valid_q;
    assign out_pc        = out_q.pc;
    assign out_rd        = out_q.rd;
    assign out_rs1       = out_q.rs1;
    assign out_rs2       = out_q.rs2;
    assign out_funct3    = out_q.funct3;
    assign out_imm       = out_q.imm;
    assign out_type      = out_q.itype;
    assign out_alu_op    = out_q.alu_op;
    assign out_wr_en     = out_q.wr_en;
    assign out_is_load   = out_q.is_load;
    assign out_is_store  = out_q.is_store;
    assign out_is_branch = out_q.is_branch;
    assign out_is_jump   = out_q.is_jump;
    assign out_illegal   = out_q.illegal;

endmodule

// File: tb/tb_decode_stage.sv
// ----------------------------------------------------------------------------
// tb_decode_stage
//   Directed bench for decode_stage with default parameters. Expected values
//   are hand-computed from the instruction encodings.
// ----------------------------------------------------------------------------
module tb_decode_stage;

    localparam logic [5:0] T_U = 6'b000001;
    localparam logic [5:0] T_I = 6'b000010;
    localparam logic [5:0] T_S = 6'b000100;
    localparam logic [5:0] T_R = 6'b001000;
    localparam logic [5:0] T_B = 6'b010000;
    localparam logic [5:0] T_J = 6'b100000;

    logic        clk;
    logic        rst_n;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_instr;
    logic [31:0] in_pc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_pc;
    logic [4:0]  out_rd, out_rs1, out_rs2;
    logic [2:0]  out_funct3;
    logic [31:0] out_imm;
    logic [5:0]  out_type;
    logic [3:0]  out_alu_op;
    logic        out_wr_en, out_is_load, out_is_store, out_is_branch, out_is_jump;
    logic        out_illegal;

    int checks = 0;
    int errors = 0;

    decode_stage dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .flush        (flush),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_instr     (in_instr),
        .in_pc        (in_pc),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_pc       (out_pc),
        .out_rd       (out_rd),
        .out_rs1      (out_rs1),
        .out_rs2      (out_rs2),
        .out_funct3   (out_funct3),
        .out_imm      (out_imm),
        .out_type     (out_type),
        .out_alu_op   (out_alu_op),
        .out_wr_en    (out_wr_en),
        .out_is_load  (out_is_load),
        .out_is_store (out_is_store),
        .out_is_branch(out_is_branch),
        .out_is_jump  (out_is_jump),
        .out_illegal  (out_illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    // Present one instruction for one edge, then sample just after it.
    task automatic send(input logic [31:0] instr, input logic [31:0] pc);
        in_valid = 1'b1;
        in_instr = instr;
        in_pc    = pc;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    logic [31:0] pcs [5];
    int          idx;
    int          got;
    logic        fire;

    initial begin
        pcs = '{32'h1000, 32'h1004, 32'h1008, 32'h100C, 32'h1010};
        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0;
        in_instr = '0; in_pc = '0; out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid", out_valid, 0);
        check("rst_in_ready",  in_ready,  1);
        check("rst_imm",       out_imm,   0);
        check("rst_type",      out_type,  0);
        check("rst_wr_en",     out_wr_en, 0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // addi x1,x0,5
        send(32'h00500093, 32'h100);
        check("addi_valid", out_valid, 1);
        check("addi_pc",    out_pc, 32'h100);
        check("addi_rd",    out_rd, 1);
        check("addi_rs1",   out_rs1, 0);
        check("addi_rs2",   out_rs2, 0);
        check("addi_imm",   out_imm, 5);
        check("addi_type",  out_type, T_I);
        check("addi_alu",   out_alu_op, 0);
        check("addi_wr_en", out_wr_en, 1);

        // sub x3,x1,x2
        send(32'h402081B3, 32'h104);
        check("sub_alu",   out_alu_op, 1);
        check("sub_type",  out_type, T_R);
        check("sub_imm",   out_imm, 0);
        check("sub_rd",    out_rd, 3);
        check("sub_rs2",   out_rs2, 2);
        check("sub_wr_en", out_wr_en, 1);

        // beq x1,x2,+8
        send(32'h00208463, 32'h108);
        check("beq_imm",    out_imm, 8);
        check("beq_branch", out_is_branch, 1);
        check("beq_wr_en",  out_wr_en, 0);
        check("beq_rd",     out_rd, 0);
        check("beq_alu",    out_alu_op, 5);
        check("beq_type",   out_type, T_B);

        // lui x5,0x12345
        send(32'h123452B7, 32'h10C);
        check("lui_imm",  out_imm, 32'h12345000);
        check("lui_alu",  out_alu_op, 10);
        check("lui_type", out_type, T_U);
        check("lui_rd",   out_rd, 5);
        check("lui_rs1",  out_rs1, 0);

        // srai x1,x2,3: instr[30] selects SRA for OP-IMM
        send(32'h40315093, 32'h110);
        check("srai_alu", out_alu_op, 7);
        check("srai_rs1", out_rs1, 2);

        // addi x1,x0,0x400: instr[30] set but OP-IMM stays ADD
        send(32'h40000093, 32'h114);
        check("addi30_alu", out_alu_op, 0);
        check("addi30_imm", out_imm, 32'h400);

        // sw x2,-4(x1): negative S immediate
        send(32'hFE20AE23, 32'h118);
        check("sw_imm",   out_imm, 32'hFFFFFFFC);
        check("sw_store", out_is_store, 1);
        check("sw_type",  out_type, T_S);
        check("sw_rd",    out_rd, 0);
        check("sw_wr_en", out_wr_en, 0);

        // jal x1,+2048
        send(32'h001000EF, 32'h11C);
        check("jal_imm",   out_imm, 32'h800);
        check("jal_type",  out_type, T_J);
        check("jal_jump",  out_is_jump, 1);
        check("jal_wr_en", out_wr_en, 1);

        // bltu x1,x2,+8
        send(32'h0020E463, 32'h120);
        check("bltu_alu", out_alu_op, 4);

        // all-ones word: unrecognised opcode
        send(32'hFFFFFFFF, 32'h124);
        check("ones_type",  out_type, 0);
        check("ones_wr_en", out_wr_en, 0);
`ifdef DECODE_STAGE_ILLEGAL_CHECK_EN
        check("ones_illegal", out_illegal, 1);
`else
        check("ones_illegal", out_illegal, 0);
`endif

        @(posedge clk);
        #1;
        check("drain_valid", out_valid, 0);

        // Backpressure: 4 stalled cycles, 5 distinct PCs offered
        out_ready = 1'b0;
        idx = 0;
        for (int c = 0; c < 4; c++) begin
            in_valid = (idx < 5);
            in_instr = 32'h00000013;
            in_pc    = (idx < 5) ? pcs[idx] : 32'h0;
            fire     = in_valid && in_ready;
            @(posedge clk);
            #1;
            if (fire) idx++;
        end
        check("bp_accepts",  idx, 3);
        check("bp_in_ready", in_ready, 0);
        check("bp_head_pc",  out_pc, pcs[0]);

        out_ready = 1'b1;
        got = 0;
        for (int c = 0; c < 40 && got < 5; c++) begin
            in_valid = (idx < 5);
            in_pc    = (idx < 5) ? pcs[idx] : 32'h0;
            fire     = in_valid && in_ready;
            if (out_valid) begin
                check("bp_order", out_pc, pcs[got]);
                got++;
            end
            @(posedge clk);
            #1;
            if (fire) idx++;
            if (c == 0) check("bp_in_ready_reassert", in_ready, 1);
        end
        in_valid = 1'b0;
        check("bp_out_count", got, 5);
        check("bp_in_count",  idx, 5);

        // Flush with skid full
        out_ready = 1'b0;
        for (int c = 0; c < 10 && in_ready; c++) send(32'h00000013, 32'h2000 + 32'(c * 4));
        check("fl_full", in_ready, 0);
        flush = 1'b1;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        in_valid = 1'b0;
        check("fl_out_valid", out_valid, 0);
        check("fl_in_ready",  in_ready, 1);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        check("fl_nothing_left", out_valid, 0);

        // Input firing together with flush is dropped
        flush = 1'b1;
        send(32'h00500093, 32'h3000);
        flush = 1'b0;
        check("fl_drop_valid", out_valid, 0);
        @(posedge clk);
        #1;
        check("fl_drop_later", out_valid, 0);

        // Asynchronous reset mid-operation
        out_ready = 1'b0;
        send(32'h00500093, 32'h4000);
        send(32'h00500093, 32'h4004);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_out_valid", out_valid, 0);
        check("arst_in_ready",  in_ready, 1);
        check("arst_pc",        out_pc, 0);
        #1;
        rst_n = 1'b1;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        check("arst_discarded", out_valid, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout got=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
